cache_plru_engine: RTL and testbench

Stores and maintains tree pseudo-LRU state for every set of a parametrised set-associative cache. Owns the PLRU bit array for the whole cache, applies promote (hit/fill) and demote (invalidate) updates, and answers registered victim queries. Sits beside the tag/data arrays in the cache controller, generalising the fixed 8-way combinational update into a stateful multi-set engine with initialisation sweep, soft flush and same-cycle forwarding.

---
 rtl/cache_plru_pkg.sv | 60 ++++++
 rtl/cache_plru_tree.sv | 21 ++
 rtl/cache_plru_engine.sv | 105 ++++++++++
 tb/tb_cache_plru_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_plru_pkg.sv
// Shared types and tree pseudo-LRU helpers for the PLRU engine.
// Helpers work on the widest supported tree (64 ways) and take the tree depth as an argument.
package cache_plru_pkg;

    localparam int MAX_LEVELS = 6;
    localparam int MAX_BITS   = 63;

    typedef logic [MAX_BITS-1:0]   plru_bits_t;
    typedef logic [MAX_LEVELS-1:0] plru_way_t;

    typedef enum logic {INIT, RUN} plru_state_e;

    // Walk the path of 'way' from the root; each node is set away from (promote) or toward (demote) it.
    function automatic plru_bits_t plru_update(input plru_bits_t bits, input plru_way_t way,
                                               input int levels, input logic demote);
        plru_bits_t nb;
        plru_way_t  wa;
        logic [6:0] node;
        logic       dir;
        nb   = bits;
        wa   = way << (MAX_LEVELS - levels);
        node = '0;
        for (int l = 0; l < MAX_LEVELS; l++) begin
            if (l < levels) begin
                dir             = wa[MAX_LEVELS-1];
                nb[node[5:0]]   = demote ? dir : ~dir;
                node            = 7'(2 * node + 1 + dir);
                wa              = wa << 1;
            end
        end
        return nb;
    endfunction

    function automatic plru_bits_t plru_promote(input plru_bits_t bits, input plru_way_t way,
                                                input int levels);
        return plru_update(bits, way, levels, 1'b0);
    endfunction

    function automatic plru_bits_t plru_demote(input plru_bits_t bits, input plru_way_t way,
                                               input int levels);
        return plru_update(bits, way, levels, 1'b1);
    endfunction

    function automatic plru_way_t plru_victim(input plru_bits_t bits, input int levels);
        plru_way_t  way;
        logic [6:0] node;
        logic       dir;
        way  = '0;
        node = '0;
        for (int l = 0; l < MAX_LEVELS; l++) begin
            if (l < levels) begin
                dir  = bits[node[5:0]];
                way  = {way[MAX_LEVELS-2:0], dir};
                node = 7'(2 * node + 1 + dir);
            end
        end
        return way;
    endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// Combinational per-set PLRU logic: next tree bits for a touch, and the victim of the given bits.
module cache_plru_tree
    import cache_plru_pkg::*;
#(
    parameter  int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS),
    localparam int BW    = WAYS - 1
) (
    input  logic [BW-1:0]    bits,
    input  logic [WAY_W-1:0] way,
    input  logic             demote,
    output logic [BW-1:0]    new_bits,
    output logic [WAY_W-1:0] victim
);

    assign new_bits = BW'(demote ? plru_demote(plru_bits_t'(bits), plru_way_t'(way), WAY_W)
                                 : plru_promote(plru_bits_t'(bits), plru_way_t'(way), WAY_W));

    assign victim = WAY_W'(plru_victim(plru_bits_t'(bits), WAY_W));

endmodule

// File: rtl/cache_plru_engine.sv
// Multi-set tree-PLRU state engine: clearing sweep, promote/demote updates, registered victim queries.
// state | meaning
// INIT  | sweeping all-zero tree bits into one set per cycle, traffic ignored
// RUN   | array valid, accesses and victim queries accepted
module cache_plru_engine
    import cache_plru_pkg::*;
#(
    parameter  int WAYS     = 8,
    parameter  int NUM_SETS = 64,
    localparam int WAY_W    = $clog2(WAYS),
    localparam int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req,
    output logic             init_done,
    input  logic             acc_valid,
    output logic             acc_ready,
    input  logic [SET_W-1:0] acc_set,
    input  logic [WAY_W-1:0] acc_way,
    input  logic             acc_demote,
    input  logic             vic_req,
    input  logic [SET_W-1:0] vic_set,
    output logic             vic_valid,
    output logic [WAY_W-1:0] vic_way
);

    localparam int BW = WAYS - 1;

    logic [BW-1:0]    plru_mem [NUM_SETS];
    plru_state_e      state, next_state;
    logic [SET_W-1:0] sweep_cnt, next_cnt;

    logic             acc_fire, vic_fire;
    logic [BW-1:0]    upd_bits, q_bits;
    logic [WAY_W-1:0] q_victim;
    logic [WAY_W-1:0] upd_victim_unused;
    logic [BW-1:0]    q_new_bits_unused;

    assign init_done = (state == RUN);
    assign acc_ready = init_done;
    assign acc_fire  = acc_valid & init_done & ~flush_req;
    assign vic_fire  = vic_req & init_done & ~flush_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= next_state;
            sweep_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = sweep_cnt;
        if (flush_req) begin
            next_state = INIT;
            next_cnt   = '0;
        end else if (state == INIT) begin
            if (sweep_cnt == SET_W'(NUM_SETS - 1)) next_state = RUN;
            next_cnt = sweep_cnt + 1'b1;
        end
    end

    cache_plru_tree #(.WAYS(WAYS)) u_upd_tree (
        .bits     (plru_mem[acc_set]),
        .way      (acc_way),
        .demote   (acc_demote),
        .new_bits (upd_bits),
        .victim   (upd_victim_unused)
    );

    // Same-set access in the query cycle: the victim reflects the bits being written this cycle.
    assign q_bits = (acc_fire && (acc_set == vic_set)) ? upd_bits : plru_mem[vic_set];

    cache_plru_tree #(.WAYS(WAYS)) u_query_tree (
        .bits     (q_bits),
        .way      ('0),
        .demote   (1'b0),
        .new_bits (q_new_bits_unused),
        .victim   (q_victim)
    );

    // The array has no reset; the INIT sweep is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            plru_mem[sweep_cnt] <= '0;
        end else if (acc_fire) begin
            plru_mem[acc_set] <= upd_bits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vic_valid <= 1'b0;
            vic_way   <= '0;
        end else begin
            vic_valid <= vic_fire;
            if (vic_fire) vic_way <= q_victim;
        end
    end

endmodule

// File: tb/tb_cache_plru_engine.sv
// Scoreboard bench for cache_plru_engine (8 ways, 64 sets): queries push expected victims,
// a negedge monitor pops and compares whenever vic_valid is seen.
module tb_cache_plru_engine;

    localparam int WAYS     = 8;
    localparam int NUM_SETS = 64;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int SET_W    = $clog2(NUM_SETS);

    logic             clk;
    logic             rst_n;
    logic             flush_req;
    logic             init_done;
    logic             acc_valid;
    logic             acc_ready;
    logic [SET_W-1:0] acc_set;
    logic [WAY_W-1:0] acc_way;
    logic             acc_demote;
    logic             vic_req;
    logic [SET_W-1:0] vic_set;
    logic             vic_valid;
    logic [WAY_W-1:0] vic_way;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WAY_W-1:0] exp_q[$];
    logic [WAY_W-1:0] exp_way;
    int               cyc;

    cache_plru_engine #(.WAYS(WAYS), .NUM_SETS(NUM_SETS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_req  (flush_req),
        .init_done  (init_done),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_set    (acc_set),
        .acc_way    (acc_way),
        .acc_demote (acc_demote),
        .vic_req    (vic_req),
        .vic_set    (vic_set),
        .vic_valid  (vic_valid),
        .vic_way    (vic_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && vic_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_vic_valid: got vic_valid=1 vic_way=%0d, required no result", vic_way);
            end else begin
                exp_way = exp_q.pop_front();
                if (vic_way !== exp_way) begin
                    n_bad++;
                    $display("FAIL vic_way: got %0d, required %0d", vic_way, exp_way);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int s, input int w, input int dem);
        acc_valid  = 1'b1;
        acc_set    = SET_W'(s);
        acc_way    = WAY_W'(w);
        acc_demote = (dem != 0);
        tick();
        acc_valid  = 1'b0;
    endtask

    task automatic query(input int s, input int exp);
        vic_req = 1'b1;
        vic_set = SET_W'(s);
        exp_q.push_back(WAY_W'(exp));
        tick();
        vic_req = 1'b0;
    endtask

    task automatic access_and_query(input int as, input int aw, input int dem,
                                    input int qs, input int exp);
        acc_valid  = 1'b1;
        acc_set    = SET_W'(as);
        acc_way    = WAY_W'(aw);
        acc_demote = (dem != 0);
        vic_req    = 1'b1;
        vic_set    = SET_W'(qs);
        exp_q.push_back(WAY_W'(exp));
        tick();
        acc_valid  = 1'b0;
        vic_req    = 1'b0;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 300) begin
            tick();
            cycles++;
        end
    endtask

    task automatic drain(input string name);
        repeat (3) tick();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        flush_req  = 1'b0;
        acc_valid  = 1'b0;
        acc_set    = '0;
        acc_way    = '0;
        acc_demote = 1'b0;
        vic_req    = 1'b0;
        vic_set    = '0;

        tick();
        tick();
        check("reset_init_done", int'(init_done), 0);
        check("reset_acc_ready", int'(acc_ready), 0);
        check("reset_vic_valid", int'(vic_valid), 0);
        check("reset_vic_way", int'(vic_way), 0);

        rst_n = 1'b1;
        wait_init(cyc);
        check("init_cycles", cyc, NUM_SETS);
        check("acc_ready_after_init", int'(acc_ready), 1);

        query(5, 0);
        access(5, 0, 0);
        query(5, 4);
        access(5, 4, 0);
        query(5, 2);

        access(9, 6, 1);
        query(9, 6);
        query(10, 0);

        access_and_query(3, 0, 0, 3, 4);
        access_and_query(6, 0, 0, 4, 0);
        query(6, 4);

        access(7, 0, 0);
        access(7, 4, 0);
        query(7, 2);
        access(7, 7, 1);
        query(7, 7);
        drain("queue_empty_run");

        // Flush: traffic offered during the sweep must be ignored.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("flush_init_done_low", int'(init_done), 0);
        acc_valid  = 1'b1;
        acc_set    = SET_W'(5);
        acc_way    = '0;
        acc_demote = 1'b0;
        vic_req    = 1'b1;
        vic_set    = SET_W'(5);
        repeat (10) tick();
        acc_valid = 1'b0;
        vic_req   = 1'b0;
        wait_init(cyc);
        check("flush_sweep_cycles", cyc + 10, NUM_SETS);
        for (int i = 0; i < 11; i++) query(i, 0);
        query(NUM_SETS - 1, 0);
        drain("queue_empty_flush");

        // Reset with a query result on the outputs, then reset again mid-sweep.
        access(12, 0, 0);
        vic_req = 1'b1;
        vic_set = SET_W'(12);
        tick();
        vic_req = 1'b0;
        check("inflight_vic_valid", int'(vic_valid), 1);
        check("inflight_vic_way", int'(vic_way), 4);
        rst_n = 1'b0;
        #1;
        check("async_rst_vic_valid", int'(vic_valid), 0);
        check("async_rst_vic_way", int'(vic_way), 0);
        check("async_rst_init_done", int'(init_done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("mid_sweep_init_done", int'(init_done), 0);
        rst_n = 1'b0;
        #1;
        check("mid_sweep_rst_init_done", int'(init_done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_init(cyc);
        check("resweep_cycles", cyc, NUM_SETS);
        query(12, 0);
        query(5, 0);
        drain("queue_empty_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
